// File: rtl/ecc_89_err_monitor.sv
// ECC error monitor: saturating sbit/dbit/fault counters, first-error log, alarm FSM with registered irq.
// Latency: counters, log and irq update on the edge that samples the event, visible next cycle.
// Backpressure: none, every qualified read is accepted. Optional ECC_MON_ADDR_LOG_EN adds first_err_addr capture.
module ecc_89_err_monitor #(
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_vld,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  sbit_err,
    input  logic                  dbit_err,
    input  logic                  ecc_fault,
    input  logic [CNT_WIDTH-1:0]  sbit_thr,
    input  logic                  clr_req,
    output logic                  clr_ack,
    output logic [CNT_WIDTH-1:0]  sbit_cnt,
    output logic [CNT_WIDTH-1:0]  dbit_cnt,
    output logic [CNT_WIDTH-1:0]  fault_cnt,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [1:0]            first_err_type,
    output logic                  irq
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOGGED = 2'b01,
        ALARM  = 2'b10
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                 state;
    state_t                 state_base;
    state_t                 state_nxt;
    logic                   clr_req_q;
    logic                   clr_fire;
    logic                   sbit_ev;
    logic                   dbit_ev;
    logic                   fault_ev;
    logic                   any_ev;
    logic                   log_first;
    logic                   alarm_trig;
    logic [1:0]             ev_type;
    logic [CNT_WIDTH-1:0]   sbit_base;
    logic [CNT_WIDTH-1:0]   dbit_base;
    logic [CNT_WIDTH-1:0]   fault_base;
    logic [CNT_WIDTH-1:0]   sbit_nxt;
    logic [CNT_WIDTH-1:0]   dbit_nxt;
    logic [CNT_WIDTH-1:0]   fault_nxt;

    // Clear acts on the rising edge of clr_req; an event on that same edge lands on the cleared state.
    assign clr_fire = clr_req & ~clr_req_q;

    always_comb begin
        sbit_ev    = rd_vld & sbit_err;
        dbit_ev    = rd_vld & dbit_err;
        fault_ev   = rd_vld & ecc_fault;
        any_ev     = sbit_ev | dbit_ev | fault_ev;

        sbit_base  = clr_fire ? '0 : sbit_cnt;
        dbit_base  = clr_fire ? '0 : dbit_cnt;
        fault_base = clr_fire ? '0 : fault_cnt;
        state_base = clr_fire ? IDLE : state;

        sbit_nxt   = (sbit_ev  && sbit_base  != CNT_MAX) ? sbit_base  + 1'b1 : sbit_base;
        dbit_nxt   = (dbit_ev  && dbit_base  != CNT_MAX) ? dbit_base  + 1'b1 : dbit_base;
        fault_nxt  = (fault_ev && fault_base != CNT_MAX) ? fault_base + 1'b1 : fault_base;

        if (fault_ev) begin
            ev_type = 2'b11;
        end else if (dbit_ev) begin
            ev_type = 2'b10;
        end else begin
            ev_type = 2'b01;
        end

        log_first  = any_ev && (state_base == IDLE);
        // Threshold is only evaluated against a fresh sbit event, so a thr change alone never moves irq.
        alarm_trig = dbit_ev || fault_ev ||
                     (sbit_ev && (sbit_thr != '0) && (sbit_nxt >= sbit_thr));

        if (alarm_trig) begin
            state_nxt = ALARM;
        end else if (log_first) begin
            state_nxt = LOGGED;
        end else begin
            state_nxt = state_base;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            clr_req_q      <= 1'b0;
            clr_ack        <= 1'b0;
            sbit_cnt       <= '0;
            dbit_cnt       <= '0;
            fault_cnt      <= '0;
            first_err_type <= 2'b00;
            irq            <= 1'b0;
        end else begin
            state     <= state_nxt;
            clr_req_q <= clr_req;
            clr_ack   <= clr_fire;
            sbit_cnt  <= sbit_nxt;
            dbit_cnt  <= dbit_nxt;
            fault_cnt <= fault_nxt;
            irq       <= (state_nxt == ALARM);
            if (log_first) begin
                first_err_type <= ev_type;
            end else if (clr_fire) begin
                first_err_type <= 2'b00;
            end
        end
    end

`ifdef ECC_MON_ADDR_LOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_err_addr <= '0;
        end else if (log_first) begin
            first_err_addr <= rd_addr;
        end else if (clr_fire) begin
            first_err_addr <= '0;
        end
    end
`else
    assign first_err_addr = '0;

    logic unused_addr;
    assign unused_addr = ^rd_addr;
`endif

endmodule

// File: tb/tb_ecc_89_err_monitor.sv
// Bench for ecc_89_err_monitor: directed scenarios plus randomized traffic against a behavioural model.
module tb_ecc_89_err_monitor;

    localparam int AW   = 10;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_vld = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          sbit_err = 1'b0;
    logic          dbit_err = 1'b0;
    logic          ecc_fault = 1'b0;
    logic [CW-1:0] sbit_thr = '0;
    logic          clr_req = 1'b0;
    logic          clr_ack;
    logic [CW-1:0] sbit_cnt;
    logic [CW-1:0] dbit_cnt;
    logic [CW-1:0] fault_cnt;
    logic [AW-1:0] first_err_addr;
    logic [1:0]    first_err_type;
    logic          irq;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int            m_sc, m_dc, m_fc;
    bit            m_logged, m_alarm, m_ack, m_clr_prev;
    logic [1:0]    m_type;
    logic [AW-1:0] m_addr;

    ecc_89_err_monitor #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rd_vld         (rd_vld),
        .rd_addr        (rd_addr),
        .sbit_err       (sbit_err),
        .dbit_err       (dbit_err),
        .ecc_fault      (ecc_fault),
        .sbit_thr       (sbit_thr),
        .clr_req        (clr_req),
        .clr_ack        (clr_ack),
        .sbit_cnt       (sbit_cnt),
        .dbit_cnt       (dbit_cnt),
        .fault_cnt      (fault_cnt),
        .first_err_addr (first_err_addr),
        .first_err_type (first_err_type),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] a);
`ifdef ECC_MON_ADDR_LOG_EN
        return a;
`else
        return '0;
`endif
    endfunction

    task automatic model_reset();
        m_sc = 0; m_dc = 0; m_fc = 0;
        m_logged = 0; m_alarm = 0; m_ack = 0; m_clr_prev = 0;
        m_type = 2'b00; m_addr = '0;
    endtask

    // Drive one cycle of inputs (from a negedge), advance the model at the posedge, return at the next negedge.
    task automatic drive_cycle(input logic v, input logic [AW-1:0] a,
                               input logic s, input logic d, input logic f, input logic cr);
        bit fire;
        rd_vld = v; rd_addr = a; sbit_err = s; dbit_err = d; ecc_fault = f; clr_req = cr;
        @(posedge clk);
        fire = cr && !m_clr_prev;
        m_clr_prev = cr;
        m_ack = fire;
        if (fire) begin
            m_sc = 0; m_dc = 0; m_fc = 0;
            m_logged = 0; m_alarm = 0; m_type = 2'b00; m_addr = '0;
        end
        if (v) begin
            if (s && m_sc < CMAX) m_sc++;
            if (d && m_dc < CMAX) m_dc++;
            if (f && m_fc < CMAX) m_fc++;
            if ((s || d || f) && !m_logged) begin
                m_logged = 1;
                m_type = f ? 2'b11 : (d ? 2'b10 : 2'b01);
                m_addr = a;
            end
            if (d || f) m_alarm = 1;
            if (s && sbit_thr != 0 && m_sc >= int'(sbit_thr)) m_alarm = 1;
        end
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, clr_req);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rd_vld = 0; sbit_err = 0; dbit_err = 0; ecc_fault = 0; clr_req = 0; rd_addr = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({clr_ack, irq, first_err_type, first_err_addr, sbit_cnt, dbit_cnt, fault_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state got ack=%b irq=%b type=%b addr=%h s=%0d d=%0d f=%0d want all zero",
                     clr_ack, irq, first_err_type, first_err_addr, sbit_cnt, dbit_cnt, fault_cnt);
        end
    endtask

    task automatic test_sbit_threshold();
        do_reset();
        sbit_thr = 8'd3;
        drive_cycle(1, 10'h005, 1, 0, 0, 0);
        drive_cycle(1, 10'h006, 1, 0, 0, 0);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL thr_irq_early got %b want 0", irq); end
        drive_cycle(1, 10'h007, 1, 0, 0, 0);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL thr_irq_third got %b want 1", irq); end
        checks++;
        if (sbit_cnt !== 8'd3) begin errors++; $display("FAIL thr_sbit_cnt got %0d want 3", sbit_cnt); end
        checks++;
        if (first_err_type !== 2'b01) begin errors++; $display("FAIL thr_type got %b want 01", first_err_type); end
        checks++;
        if (first_err_addr !== exp_addr(10'h005)) begin
            errors++; $display("FAIL thr_addr got %h want %h", first_err_addr, exp_addr(10'h005));
        end
    endtask

    task automatic test_dbit_and_unqualified();
        do_reset();
        sbit_thr = 8'd0;
        drive_cycle(1, 10'h3FF, 0, 1, 0, 0);
        checks++;
        if ({irq, dbit_cnt, first_err_type} !== {1'b1, 8'd1, 2'b10}) begin
            errors++; $display("FAIL dbit_event got irq=%b dbit=%0d type=%b want 1/1/10", irq, dbit_cnt, first_err_type);
        end
        checks++;
        if (first_err_addr !== exp_addr(10'h3FF)) begin
            errors++; $display("FAIL dbit_addr got %h want %h", first_err_addr, exp_addr(10'h3FF));
        end
        drive_cycle(0, 10'h011, 1, 0, 0, 0);
        checks++;
        if ({sbit_cnt, first_err_type} !== {8'd0, 2'b10}) begin
            errors++; $display("FAIL unqualified got sbit=%0d type=%b want 0/10", sbit_cnt, first_err_type);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        drive_cycle(1, 10'h123, 1, 0, 1, 0);
        checks++;
        if ({sbit_cnt, fault_cnt, first_err_type, irq} !== {8'd1, 8'd1, 2'b11, 1'b1}) begin
            errors++; $display("FAIL simultaneous got s=%0d f=%0d type=%b irq=%b want 1/1/11/1",
                               sbit_cnt, fault_cnt, first_err_type, irq);
        end
        checks++;
        if (first_err_addr !== exp_addr(10'h123)) begin
            errors++; $display("FAIL addr_log got %h want %h", first_err_addr, exp_addr(10'h123));
        end
    endtask

    task automatic test_saturation();
        do_reset();
        sbit_thr = 8'd0;
        for (int i = 0; i < 300; i++) drive_cycle(1, 10'(i), 1, 0, 0, 0);
        checks++;
        if (sbit_cnt !== 8'd255) begin errors++; $display("FAIL saturate got %0d want 255", sbit_cnt); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL thr_zero_irq got %b want 0", irq); end
        drive_cycle(1, 10'h001, 1, 0, 0, 0);
        checks++;
        if (sbit_cnt !== 8'd255) begin errors++; $display("FAIL saturate_hold got %0d want 255", sbit_cnt); end
    endtask

    task automatic test_thr_change();
        do_reset();
        sbit_thr = 8'd0;
        drive_cycle(1, 10'h040, 1, 0, 0, 0);
        drive_cycle(1, 10'h041, 1, 0, 0, 0);
        sbit_thr = 8'd1;
        idle_cycle();
        idle_cycle();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL thr_change_raise got %b want 0", irq); end
        drive_cycle(1, 10'h042, 1, 0, 0, 0);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL thr_change_next got %b want 1", irq); end
        sbit_thr = 8'd0;
        idle_cycle();
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL thr_change_drop got %b want 1", irq); end
    endtask

    task automatic test_clear_hold();
        int acks;
        do_reset();
        sbit_thr = 8'd2;
        drive_cycle(1, 10'h010, 0, 0, 1, 0);
        drive_cycle(1, 10'h011, 1, 0, 0, 0);
        drive_cycle(1, 10'h2A0, 0, 1, 0, 1);
        acks = int'(clr_ack);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(0, '0, 0, 0, 0, 1);
            acks += int'(clr_ack);
        end
        checks++;
        if (acks != 1) begin errors++; $display("FAIL clear_ack_count got %0d want 1", acks); end
        checks++;
        if ({sbit_cnt, dbit_cnt, fault_cnt, first_err_type, irq} !== {8'd0, 8'd1, 8'd0, 2'b10, 1'b1}) begin
            errors++; $display("FAIL clear_state got s=%0d d=%0d f=%0d type=%b irq=%b want 0/1/0/10/1",
                               sbit_cnt, dbit_cnt, fault_cnt, first_err_type, irq);
        end
        checks++;
        if (first_err_addr !== exp_addr(10'h2A0)) begin
            errors++; $display("FAIL clear_addr got %h want %h", first_err_addr, exp_addr(10'h2A0));
        end
        drive_cycle(0, '0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_clear();
        do_reset();
        drive_cycle(1, 10'h055, 1, 0, 0, 0);
        clr_req = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if ({clr_ack, sbit_cnt, irq} !== {1'b0, 8'd0, 1'b0}) begin
            errors++; $display("FAIL reset_mid_clear got ack=%b s=%0d irq=%b want 0/0/0", clr_ack, sbit_cnt, irq);
        end
        rst_n = 1'b1;
        drive_cycle(0, '0, 0, 0, 0, 1);
        checks++;
        if (clr_ack !== 1'b1) begin errors++; $display("FAIL release_new_clear got %b want 1", clr_ack); end
        drive_cycle(0, '0, 0, 0, 0, 1);
        checks++;
        if (clr_ack !== 1'b0) begin errors++; $display("FAIL clear_one_pulse got %b want 0", clr_ack); end
        drive_cycle(0, '0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [AW+3*CW+4:0] got, exp;
        do_reset();
        sbit_thr = 8'd4;
        for (int i = 0; i < 1500; i++) begin
            logic v, s, d, f, cr;
            v  = ($urandom_range(0, 9) < 7);
            s  = ($urandom_range(0, 9) < 4);
            d  = ($urandom_range(0, 19) == 0);
            f  = ($urandom_range(0, 29) == 0);
            cr = ($urandom_range(0, 9) == 0) ? ~clr_req : clr_req;
            if ($urandom_range(0, 49) == 0) sbit_thr = CW'($urandom_range(0, 6));
            drive_cycle(v, AW'($urandom), s, d, f, cr);
            exp = {m_ack, m_alarm, m_type, exp_addr(m_addr), CW'(m_sc), CW'(m_dc), CW'(m_fc)};
            got = {clr_ack, irq, first_err_type, first_err_addr, sbit_cnt, dbit_cnt, fault_cnt};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random cycle %0d got ack/irq/type/addr/s/d/f=%h want %h", i, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sbit_threshold();
        test_dbit_and_unqualified();
        test_simultaneous();
        test_saturation();
        test_thr_change();
        test_clear_hold();
        test_reset_mid_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
